// File: rtl/post_sequence_reader.sv
// Read side of the POST sequence recorder. It walks the code buffer and shows one entry
// (code and index) at a time. Supports manual step, auto-scroll and follow-latest.
module post_sequence_reader #(
    parameter int DEPTH        = 32,
    parameter int ADDR_W       = 5,
    parameter int READ_LATENCY = 1,
    parameter int DWELL_CYCLES = 25000000
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [ADDR_W:0]   EntryCount,
    input  logic              Overflow,
    input  logic [7:0]        ReadData,
    output logic [ADDR_W-1:0] ReadAddr,
    input  logic              StepNext,
    input  logic              StepPrev,
    input  logic              AutoScroll,
    output logic [7:0]        DisplayCode,
    output logic [ADDR_W-1:0] DisplayIndex,
    output logic              DisplayValid,
    output logic              Following,
    output logic              OverflowBlink
);
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int LAT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(READ_LATENCY);
    localparam logic [ADDR_W:0]   DEPTH_W    = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SHOW} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        code_q;
    logic [ADDR_W-1:0] index_q;
    logic              valid_q;
    logic              following_q;
    logic [LAT_W-1:0]  lat_q;
    logic [CNT_W-1:0]  dwell_q;
    logic [CNT_W-1:0]  blink_cnt_q;
    logic              phase_q;
    logic              oblink_q;

    logic [ADDR_W:0]   n_eff;
    logic [ADDR_W-1:0] n_last;
    logic [ADDR_W-1:0] idx_inc;
    logic [ADDR_W-1:0] idx_dec;
    logic              show_idle;
    logic              show_fetch;
    logic [ADDR_W-1:0] show_target;
    logic [CNT_W-1:0]  dwell_d;

    // Index arithmetic wraps at the effective entry count, not at DEPTH.
    always_comb begin
        n_eff   = (EntryCount > DEPTH_W) ? DEPTH_W : EntryCount;
        n_last  = ADDR_W'(n_eff - 1'b1);
        idx_inc = (index_q == n_last) ? '0 : index_q + 1'b1;
        idx_dec = (index_q == '0) ? n_last : index_q - 1'b1;
    end

    // SHOW decision in priority order; the first matching rule wins.
    always_comb begin
        show_idle   = 1'b0;
        show_fetch  = 1'b0;
        show_target = index_q;
        dwell_d     = '0;
        if (n_eff == '0) begin
            show_idle = 1'b1;
        end else if ({1'b0, index_q} >= n_eff) begin
            show_fetch  = 1'b1;
            show_target = n_last;
        end else if (StepNext && StepPrev) begin
            dwell_d = AutoScroll ? dwell_q : '0;
        end else if (StepNext) begin
            show_fetch  = 1'b1;
            show_target = idx_inc;
        end else if (StepPrev) begin
            show_fetch  = 1'b1;
            show_target = idx_dec;
        end else if (AutoScroll) begin
            if (dwell_q == DWELL_LAST) begin
                show_fetch  = 1'b1;
                show_target = idx_inc;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end else if (following_q && (index_q != n_last)) begin
            show_fetch  = 1'b1;
            show_target = n_last;
        end else if (following_q && (ReadData != code_q)) begin
            show_fetch  = 1'b1;
            show_target = index_q;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            code_q      <= '0;
            index_q     <= '0;
            valid_q     <= 1'b0;
            following_q <= 1'b1;
            lat_q       <= '0;
            dwell_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dwell_q <= '0;
                    if (n_eff != '0) begin
                        state_q <= ST_FETCH;
                        addr_q  <= '0;
                        lat_q   <= '0;
                    end
                end
                ST_FETCH: begin
                    dwell_q <= '0;
                    if (n_eff == '0) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        index_q <= '0;
                    end else if (lat_q == LAT_LAST) begin
                        state_q     <= ST_SHOW;
                        code_q      <= ReadData;
                        index_q     <= addr_q;
                        valid_q     <= 1'b1;
                        following_q <= (addr_q == n_last);
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    dwell_q <= dwell_d;
                    if (show_idle) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        index_q <= '0;
                    end else if (show_fetch) begin
                        state_q <= ST_FETCH;
                        addr_q  <= show_target;
                        lat_q   <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Free-running blink phase, independent of the display state.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            oblink_q    <= 1'b0;
        end else begin
            oblink_q <= Overflow & phase_q;
            if (blink_cnt_q == DWELL_LAST) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign ReadAddr      = addr_q;
    assign DisplayCode   = code_q;
    assign DisplayIndex  = index_q;
    assign DisplayValid  = valid_q;
    assign Following     = following_q;
    assign OverflowBlink = oblink_q;
endmodule
